// File: rtl/pipe_skid_register.sv
// Two-entry elastic pipeline register: main slot drives the output, skid slot
// absorbs one beat of back-pressure so in_ready depends only on registered state.
module pipe_skid_register #(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [n-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  logic [n-1:0] main;
  logic [n-1:0] skid;
  logic         in_fire;
  logic         out_fire;

  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    count     = 2'd0;
    case (state)
      EMPTY: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        count     = 2'd0;
      end
      ONE: begin
        out_valid = 1'b1;
        in_ready  = 1'b1;
        count     = 2'd1;
      end
      FULL: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        count     = 2'd2;
      end
      default: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        count     = 2'd0;
      end
    endcase
  end

  assign out_data = main;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Flush only retires the state; slot contents are left as-is since
  // out_valid is low until a fresh beat overwrites main.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      main  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main  <= in_data;
            state <= ONE;
          end
        end
        ONE: begin
          case ({in_fire, out_fire})
            2'b11: main <= in_data;
            2'b10: begin
              skid  <= in_data;
              state <= FULL;
            end
            2'b01: state <= EMPTY;
            default: state <= ONE;
          endcase
        end
        FULL: begin
          if (out_fire) begin
            main  <= skid;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_register.sv
// Bench for pipe_skid_register: directed vector table, reset/width sequences,
// and a randomized run against a queue-based occupancy model.
module tb_pipe_skid_register;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic [31:0] out_data;
  logic        in_ready;
  logic        out_valid;
  logic [1:0]  count;

  logic [0:0]  d1, o1;
  logic        r1, v1;
  logic [1:0]  c1;
  logic [63:0] d64, o64;
  logic        r64, v64;
  logic [1:0]  c64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_skid_register #(.n(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  pipe_skid_register #(.n(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(d1), .in_valid(in_valid), .in_ready(r1),
    .out_data(o1), .out_valid(v1), .out_ready(out_ready),
    .count(c1)
  );

  pipe_skid_register #(.n(64)) dut_w64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(d64), .in_valid(in_valid), .in_ready(r64),
    .out_data(o64), .out_valid(v64), .out_ready(out_ready),
    .count(c64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_data = '0; d1 = '0; d64 = '0;
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic        er;
    logic [1:0]  ec;
    logic        cd;
    logic [31:0] edata;
  } vec_t;

  vec_t vt[18];

  logic [31:0] q[$];
  logic [63:0] pat;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_data = '0; d1 = '0; d64 = '0;

    // expected values are the outputs seen just after the edge that applied the inputs
    vt[0]  = '{1'b1, 32'h1,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h1};
    vt[1]  = '{1'b1, 32'h2,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h2};
    vt[2]  = '{1'b1, 32'h3,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h3};
    vt[3]  = '{1'b1, 32'h4,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h4};
    vt[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h4};
    vt[5]  = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'hA};
    vt[6]  = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'hA};
    vt[7]  = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'hA};
    vt[8]  = '{1'b1, 32'hC,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'hB};
    vt[9]  = '{1'b1, 32'hC,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'hC};
    vt[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'hC};
    vt[11] = '{1'b1, 32'h5,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h5};
    vt[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h5};
    vt[13] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h5};
    vt[14] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h11};
    vt[15] = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'h11};
    vt[16] = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0};
    vt[17] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0};

    #1;
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_count", {62'd0, count}, 64'd0);
    chk("reset_data", {32'd0, out_data}, 64'd0);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      in_valid = vt[i].iv; in_data = vt[i].d;
      out_ready = vt[i].ordy; flush = vt[i].fl;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, {63'd0, vt[i].ev});
      chk($sformatf("vec%0d_ready", i), {63'd0, in_ready}, {63'd0, vt[i].er});
      chk($sformatf("vec%0d_count", i), {62'd0, count}, {62'd0, vt[i].ec});
      if (vt[i].cd)
        chk($sformatf("vec%0d_data", i), {32'd0, out_data}, {32'd0, vt[i].edata});
    end

    // asynchronous reset while FULL, no clock edge involved
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
    @(negedge clk);
    in_data = 32'h88;
    @(posedge clk);
    #1;
    chk("pre_reset_count", {62'd0, count}, 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("async_rst_count", {62'd0, count}, 64'd0);
    chk("async_rst_data", {32'd0, out_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_accept_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_accept_data", {32'd0, out_data}, 64'h99);
    chk("post_rst_accept_count", {62'd0, count}, 64'd1);

    // width sweep with alternating all-ones / all-zeros
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat = (i % 2 == 0) ? '1 : '0;
      in_valid = 1'b1; out_ready = 1'b1;
      d1 = pat[0]; d64 = pat;
      @(posedge clk);
      #1;
      chk($sformatf("w1_data%0d", i), {63'd0, o1}, {63'd0, pat[0]});
      chk($sformatf("w64_data%0d", i), o64, pat);
      chk($sformatf("w1_valid%0d", i), {63'd0, v1}, 64'd1);
      chk($sformatf("w64_ready%0d", i), {63'd0, r64}, 64'd1);
    end

    // randomized run against an occupancy queue of capacity two
    do_reset();
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("rnd_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      chk("rnd_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
      chk("rnd_count", {62'd0, count}, 64'(q.size()));
      if (q.size() > 0)
        chk("rnd_data", {32'd0, out_data}, {32'd0, q[0]});
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_data   = $urandom;
      @(posedge clk);
      begin
        bit inf, outf;
        inf  = in_valid && (q.size() < 2);
        outf = out_ready && (q.size() > 0);
        if (flush) q.delete();
        else begin
          if (outf) void'(q.pop_front());
          if (inf) q.push_back(in_data);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_register.md
# pipe_skid_register

Two-entry elastic pipeline register (main + skid slot) with valid/ready handshakes on both sides, placed between CPU pipeline stages (e.g. fetch→decode) in place of a plain enable-gated `Register`. It sustains one transfer per cycle. It absorbs one beat of downstream back-pressure without a combinational ready path from `out_ready` to `in_ready`. It supports a synchronous flush for branch/exception squashing.

## Interface
- `n`, default 32: payload width in bits.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `flush`, input, 1: synchronous squash of all buffered beats.
- `in_data`, input, n: upstream payload.
- `in_valid`, input, 1: upstream offers `in_data`.
- `in_ready`, output, 1: block can accept a beat this cycle.
- `out_data`, output, n: payload of the oldest buffered beat.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: downstream accepts this cycle.
- `count`, output, 2: occupancy, 0..2.

## Operation
- Handshake definitions:
  - in_fire = `in_valid & in_ready`.
  - out_fire = `out_valid & out_ready`.
- Storage is two n-bit registers: `main` drives `out_data`, and `skid` holds the overflow beat.
- State register has three states: EMPTY (count 0), ONE (count 1), FULL (count 2).
- Outputs are decoded from registered state only:
  - `out_valid` = (state != EMPTY).
  - `in_ready` = (state != FULL).
  - `count` = 0/1/2 for EMPTY/ONE/FULL.
  - There is no combinational path from any input to any output.
- `out_data` = `main` at all times; it equals the last value when `out_valid`=0.
- Transitions when `flush`=0:
  - EMPTY: in_fire → `main`←`in_data`, go to ONE. Otherwise stay.
  - ONE, in_fire & out_fire → `main`←`in_data`, stay ONE.
  - ONE, in_fire & !out_fire → `skid`←`in_data`, go to FULL.
  - ONE, !in_fire & out_fire → go to EMPTY.
  - ONE, neither fire → hold.
  - FULL: in_fire is impossible. out_fire → `main`←`skid`, go to ONE. Otherwise hold.
- Flush (`flush`=1, synchronous) has priority over everything:
  - Next state is EMPTY.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed downstream.
  - `main`/`skid` contents are don't-care, with `out_valid`=0.
- Ordering: beats leave in acceptance order; none are dropped or duplicated except by flush.
- `in_valid`/`in_data` need not be held by upstream once in_fire occurs. Upstream must hold them while `in_ready`=0; the block does not check this.

## Timing
- Reset (`rst_n`=0, asynchronous, effective immediately without a clock edge):
  - state=EMPTY, `main`=0, `skid`=0.
  - Outputs: `out_valid`=0, `out_data`=0, `in_ready`=1, `count`=0.
  - Release is synchronous to the next edge; a beat offered on the first edge after release is accepted.
- Latency: a beat accepted at edge k appears on `out_data` with `out_valid`=1 after edge k (visible in cycle k+1) when the block was EMPTY.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- Back-pressure:
  - `out_ready` falling with the block in ONE plus an in_fire → FULL, `in_ready`=0 from the next cycle.
  - `in_ready` lags `out_ready` by exactly one cycle.
- Reset mid-operation: both buffered beats are lost; outputs take reset values within the same cycle `rst_n` falls.

## Test plan
- Reset: `rst_n`=0 mid-stream with count=2, no clock edge → immediately `out_valid`=0, `in_ready`=1, `count`=0, `out_data`=0.
- Streaming:
  - Stimulus: `out_ready`=1, in_valid held 1 with data 1,2,3,4 on consecutive edges.
  - Response: `out_data` shows 1,2,3,4 one cycle later with `out_valid`=1 each cycle and `in_ready` never 0.
- Back-pressure:
  - Stimulus: accept 0xA then 0xB while `out_ready`=0.
  - Response: `count`=2 and `in_ready`=0. `out_data` stays 0xA and 0xC held on `in_data` is not taken.
  - Release `out_ready`=1 → 0xA, 0xB, 0xC emerge in order on three consecutive cycles.
- Drain: single beat 0x5 with `out_ready`=1 → `out_valid` high for exactly one cycle, then EMPTY with `count`=0.
- Flush:
  - Stimulus: in FULL (0x11, 0x22), assert `flush` with `in_valid`=1 and data 0x33.
  - Response: next cycle `out_valid`=0, `count`=0, `in_ready`=1. None of 0x11/0x22/0x33 ever appear.
- Width: instantiate with n=1 and n=64; repeat the streaming test with alternating all-ones/all-zeros patterns → bit-exact output.
